// File: rtl/audio_stream_output.sv
// Interleaved audio sample FIFO feeding a paced word output, with prefill, underrun
// substitution (zero or hold-last per channel) and frame-aligned enable/disable.
module audio_stream_output #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16,
    parameter int DIV      = 4
) (
    input  logic                                          c,
    input  logic                                          rst_n,
    input  logic [WIDTH-1:0]                              in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic                                          enable,
    input  logic                                          hold_mode,
    output logic [WIDTH-1:0]                              x,
    output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] x_ch,
    output logic                                          x_valid,
    output logic                                          underrun,
    output logic [$clog2(DEPTH):0]                        level
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int NW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CW-1:0] CH_LAST  = CW'(CHANNELS - 1);
    localparam logic [NW-1:0] CNT_LAST = NW'(DIV - 1);
    localparam logic [LW-1:0] HALF     = LW'(DEPTH / 2);
    localparam logic [LW-1:0] FRAME    = LW'(CHANNELS);
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);

    typedef enum logic [1:0] {FILL, PLAY, STARVED} state_t;

    state_t           state_q, state_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    ch_q, ch_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last_q [CHANNELS];
    logic [WIDTH-1:0] x_q, word_d;
    logic [CW-1:0]    x_ch_q;
    logic             x_valid_q, underrun_q;
    logic             wr, rd, emit, subst, tick, live;

    assign wr       = in_valid && in_ready;
    assign in_ready = (level_q != FULL);
    assign level    = level_q;
    assign x        = x_q;
    assign x_ch     = x_ch_q;
    assign x_valid  = x_valid_q;
    assign underrun = underrun_q;

    // Liveness is decided once per frame at channel 0; mid-frame words follow the state,
    // since a live frame always stays in PLAY and a substituted one in STARVED.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        rd      = 1'b0;
        emit    = 1'b0;
        subst   = 1'b0;
        word_d  = '0;
        live    = (state_q == PLAY);
        tick    = (state_q != FILL) && (cnt_q == CNT_LAST);
        if (state_q == FILL) begin
            cnt_d = '0;
            ch_d  = '0;
            if (enable && level_q >= HALF) state_d = PLAY;
        end else if (!tick) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            if (ch_q == '0 && !enable) begin
                state_d = FILL;
            end else begin
                if (ch_q == '0) begin
                    live    = (state_q == PLAY) ? (level_q >= FRAME) : (level_q >= HALF);
                    state_d = live ? PLAY : STARVED;
                    subst   = !live;
                end
                emit = 1'b1;
                rd   = live;
                if (live) word_d = mem[rd_ptr_q];
                else if (hold_mode) word_d = last_q[ch_q];
                ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge c) begin
        if (wr) mem[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge c or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            ch_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            x_q        <= '0;
            x_ch_q     <= '0;
            x_valid_q  <= 1'b0;
            underrun_q <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) last_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            level_q    <= level_q + LW'(wr) - LW'(rd);
            x_valid_q  <= emit;
            underrun_q <= subst;
            if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (emit) begin
                x_q    <= word_d;
                x_ch_q <= ch_q;
            end
            if (rd) last_q[ch_q] <= word_d;
        end
    end
endmodule

// File: tb/tb_audio_stream_output.sv
// Bench for audio_stream_output: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_audio_stream_output;
    localparam int WIDTH = 32;
    localparam int CH    = 2;
    localparam int DEPTH = 16;
    localparam int DIV   = 4;
    localparam int M_FILL = 0, M_PLAY = 1, M_STARVED = 2;

    logic        c = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] inData = '0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic        enable = 1'b0;
    logic        holdMode = 1'b0;
    logic [31:0] x;
    logic        xCh;
    logic        xValid;
    logic        underrun;
    logic [4:0]  level;

    audio_stream_output #(.WIDTH(WIDTH), .CHANNELS(CH), .DEPTH(DEPTH), .DIV(DIV)) dut (
        .c(c), .rst_n(rst_n), .in_data(inData), .in_valid(inValid), .in_ready(inReady),
        .enable(enable), .hold_mode(holdMode), .x(x), .x_ch(xCh), .x_valid(xValid),
        .underrun(underrun), .level(level)
    );

    always #5 c = ~c;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;
    int cyc = 0;

    logic [31:0] mq[$];
    int          mState, mCnt, mCh;
    logic [31:0] mLast [CH];
    logic [31:0] eX;
    int          eCh;
    bit          eValid, eUnr;

    logic [31:0] logX[$];
    int          logCh[$];
    bit          logU[$];
    int          logT[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        mState = M_FILL;
        mCnt   = 0;
        mCh    = 0;
        foreach (mLast[i]) mLast[i] = '0;
        eX = '0; eCh = 0; eValid = 1'b0; eUnr = 1'b0;
    endtask

    // One clock edge of the specified behaviour, in terms of a word queue and frame rules.
    task automatic modelStep();
        bit          live, wr;
        logic [31:0] w;
        if (!rst_n) begin
            modelReset();
            return;
        end
        wr = inValid && (mq.size() != DEPTH);
        eValid = 1'b0;
        eUnr   = 1'b0;
        if (mState == M_FILL) begin
            if (enable && mq.size() >= DEPTH / 2) mState = M_PLAY;
        end else if (mCnt < DIV - 1) begin
            mCnt++;
        end else begin
            mCnt = 0;
            if (mCh == 0 && !enable) begin
                mState = M_FILL;
            end else begin
                if (mCh == 0) begin
                    live   = (mState == M_PLAY) ? (mq.size() >= CH) : (mq.size() >= DEPTH / 2);
                    mState = live ? M_PLAY : M_STARVED;
                    eUnr   = !live;
                end
                if (mState == M_PLAY) begin
                    w = mq.pop_front();
                    mLast[mCh] = w;
                end else begin
                    w = holdMode ? mLast[mCh] : 32'h0;
                end
                eX = w; eCh = mCh; eValid = 1'b1;
                mCh = (mCh + 1) % CH;
            end
        end
        if (wr) mq.push_back(inData);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge c) begin
        if (checkEn) begin
            checkOutput("x_valid", xValid, eValid);
            checkOutput("underrun", underrun, eUnr);
            checkOutput("level", level, mq.size());
            checkOutput("in_ready", inReady, mq.size() != DEPTH);
            checkOutput("x", x, eX);
            checkOutput("x_ch", xCh, eCh);
        end
    end

    task automatic stepCycle(input bit v, input logic [31:0] d, input bit en, input bit h);
        inValid = v; inData = d; enable = en; holdMode = h;
        @(posedge c);
        modelStep();
        cyc++;
        @(negedge c);
        if (xValid) begin
            logX.push_back(x);
            logCh.push_back(int'(xCh));
            logU.push_back(underrun);
            logT.push_back(cyc);
        end
    endtask

    task automatic clearLog();
        logX.delete(); logCh.delete(); logU.delete(); logT.delete();
    endtask

    task automatic waitStrobes(input int n, input int budget, input bit en, input bit h);
        int b = budget;
        while (logX.size() < n && b > 0) begin
            stepCycle(1'b0, 32'h0, en, h);
            b--;
        end
        if (logX.size() < n) checkOutput("strobeTimeout", logX.size(), n);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_x"}, x, 0);
        checkOutput({tag, "_x_ch"}, xCh, 0);
        checkOutput({tag, "_x_valid"}, xValid, 0);
        checkOutput({tag, "_underrun"}, underrun, 0);
        checkOutput({tag, "_level"}, level, 0);
        checkOutput({tag, "_in_ready"}, inReady, 1);
    endtask

    // Called at a falling edge; the reset lands between clock edges.
    task automatic asyncReset(input string tag);
        inValid = 1'b0;
        #2 rst_n = 1'b0;
        modelReset();
        #1 checkResetValues(tag);
        @(negedge c);
        @(negedge c);
        rst_n = 1'b1;
        clearLog();
    endtask

    task automatic applyStimulus(input int n, input int prob, input int enProb);
        for (int i = 0; i < n; i++) begin
            stepCycle($urandom_range(0, 99) < prob, $urandom,
                      $urandom_range(0, 99) < enProb, 1'($urandom_range(0, 1)));
        end
    endtask

    function automatic int findLiveCh0();
        for (int i = 0; i < logX.size(); i++)
            if (logCh[i] == 0 && !logU[i]) return i;
        return -1;
    endfunction

    initial begin
        int idx;
        int b;
        modelReset();
        #1 rst_n = 1'b0;
        @(negedge c);
        @(negedge c);
        checkResetValues("powerOnReset");
        rst_n = 1'b1;
        checkEn = 1'b1;

        // Prefill 1..8, play, then starve with hold and with zero substitution.
        for (int i = 1; i <= 8; i++) stepCycle(1'b1, 32'(i), 1'b0, 1'b1);
        checkOutput("prefillLevel", level, 8);
        waitStrobes(10, 200, 1'b1, 1'b1);
        checkOutput("firstX", logX[0], 1);
        checkOutput("firstCh", logCh[0], 0);
        checkOutput("secondX", logX[1], 2);
        checkOutput("secondCh", logCh[1], 1);
        checkOutput("thirdX", logX[2], 3);
        checkOutput("strobeSpacing", logT[1] - logT[0], DIV);
        checkOutput("liveNoUnderrun", logU[7], 0);
        checkOutput("holdCh0X", logX[8], 7);
        checkOutput("holdUnderrun", logU[8], 1);
        checkOutput("holdCh1X", logX[9], 8);
        checkOutput("holdCh1Ch", logCh[9], 1);
        waitStrobes(12, 100, 1'b1, 1'b0);
        checkOutput("zeroCh0X", logX[10], 0);
        checkOutput("zeroUnderrun", logU[10], 1);
        checkOutput("zeroCh1X", logX[11], 0);

        // Starved with a single queued word, then refill past half.
        clearLog();
        stepCycle(1'b1, 32'hAA, 1'b1, 1'b0);
        waitStrobes(1, 50, 1'b1, 1'b0);
        checkOutput("partialUnderrun", logU[0], 1);
        checkOutput("partialX", logX[0], 0);
        checkOutput("partialLevel", level, 1);
        for (int i = 1; i <= 7; i++) stepCycle(1'b1, 32'hB0 + 32'(i), 1'b1, 1'b0);
        b = 100;
        idx = findLiveCh0();
        while (idx < 0 && b > 0) begin
            stepCycle(1'b0, 32'h0, 1'b1, 1'b0);
            idx = findLiveCh0();
            b--;
        end
        checkOutput("refillFound", idx >= 0, 1);
        if (idx >= 0) begin
            waitStrobes(idx + 2, 50, 1'b1, 1'b0);
            checkOutput("refillCh0X", logX[idx], 32'hAA);
            checkOutput("refillCh1X", logX[idx + 1], 32'hB1);
        end

        // Overfill while disabled, then disable right after the ch0 strobe.
        asyncReset("resetBeforeFull");
        for (int i = 0; i < 17; i++) begin
            stepCycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            if (i == 15) checkOutput("inReadyFull", inReady, 0);
        end
        checkOutput("levelFull", level, 16);
        clearLog();
        waitStrobes(1, 50, 1'b1, 1'b0);
        checkOutput("fullCh0X", logX[0], 32'h100);
        for (int i = 0; i < 30; i++) stepCycle(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("strobesAfterDisable", logX.size(), 2);
        checkOutput("disableCh1X", logX[1], 32'h101);
        checkOutput("disableCh1Ch", logCh[1], 1);
        checkOutput("disableLevel", level, 14);

        // Asynchronous reset mid-frame, then the block needs a fresh prefill.
        clearLog();
        waitStrobes(3, 100, 1'b1, 1'b0);
        asyncReset("midFrameReset");
        for (int i = 0; i < 20; i++) stepCycle(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("noStrobeAfterReset", logX.size(), 0);
        for (int i = 0; i < 8; i++) stepCycle(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
        waitStrobes(2, 50, 1'b1, 1'b0);
        checkOutput("postResetX0", logX[0], 32'h200);
        checkOutput("postResetX1", logX[1], 32'h201);

        // Randomized traffic at several fill rates and enable densities.
        applyStimulus(400, 10, 95);
        applyStimulus(400, 30, 95);
        applyStimulus(400, 60, 95);
        applyStimulus(400, 90, 95);
        applyStimulus(400, 50, 60);
        applyStimulus(300, 45, 98);

        checkEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
